hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Hazard and forwarding controller for the 5-stage pipelined RV32I core.
- Generates the 2-bit operand-select codes for the EX-stage forward_a/forward_b muxes (00 = register file, 01 = MEM-stage data_to_wb, 10 = WB-stage wb_data).
- Sequences load-use bubbles, multi-cycle mul/div holds and branch-redirect flushes through a small FSM.

Parameters:
- LOAD_BUBBLES, 1: bubbles inserted per load-use hazard (1..3; matches data-memory read latency).
- REG_ADDR_W, 5: register address width.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  asynchronous active-high reset
- i_rs1_addr_id, i_rs2_addr_id  in  5  ID-stage source registers
- i_rs1_use_id, i_rs2_use_id  in  1  ID instruction reads rs1/rs2
- i_rs1_addr_ex, i_rs2_addr_ex  in  5  EX-stage source registers
- i_rd_addr_ex, i_rd_addr_mem, i_rd_addr_wb  in  5  destinations per stage
- i_rd_wren_ex, i_rd_wren_mem, i_rd_wren_wb  in  1  stage writes rd
- i_is_load_ex, i_is_load_mem  in  1  stage holds a load
- i_md_start_ex  in  1  mul/div instruction entering execution in EX
- i_md_done  in  1  mul/div result valid this cycle
- i_redirect_ex  in  1  EX branch/jump mispredict
- o_forward_a, o_forward_b  out  2  operand-select codes
- o_stall_pc, o_stall_if_id, o_stall_id_ex  out  1  hold registers
- o_flush_if_id, o_flush_id_ex, o_flush_ex_mem  out  1  insert bubble
- o_busy  out  1  FSM not in RUN
- o_stall_cnt, o_flush_cnt  out  32  performance counters

Behaviour:
- Reset: FSM = RUN, bubble counter = 0, counters = 0. All stall/flush outputs are 0; forward codes are 00.
- Forwarding (combinational from EX inputs), evaluated per operand using the rs1/rs2 addresses in EX:
  - 01 if i_rd_wren_mem && rd_mem != 0 && rd_mem == rs && !i_is_load_mem.
  - Else 10 if i_rd_wren_wb && rd_wb != 0 && rd_wb == rs.
  - Else 00. MEM has priority over WB.
- Load-use detect: i_is_load_ex && i_rd_wren_ex && rd_ex != 0 && ((use1 && rs1_id == rd_ex) || (use2 && rs2_id == rd_ex)). Register x0 never hazards.
- FSM states:
  - RUN:
    - Redirect → flush_if_id = flush_id_ex = 1 for the cycle; stay in RUN. Redirect beats load-use because the consumer is wrong-path.
    - Else load-use → stall_pc = stall_if_id = flush_id_ex = 1 this cycle. If LOAD_BUBBLES > 1, go to LD_STALL with count = LOAD_BUBBLES-1; else stay in RUN.
    - Else i_md_start_ex && !i_md_done → MD_WAIT.
  - LD_STALL: stall_pc = stall_if_id = flush_id_ex = 1. Decrement count; at count == 1 → RUN. Redirect cannot occur (a load sits in EX/MEM).
  - MD_WAIT: stall_pc = stall_if_id = stall_id_ex = flush_ex_mem = 1 until i_md_done. In the done cycle all are 0; → RUN. i_redirect_ex is ignored in MD_WAIT.
- Simultaneous md_start and md_done in RUN: single-cycle op, no stall.
- Reset mid-stall: immediate return to RUN; counters clear.
- Counters: stall_cnt increments each cycle stall_pc = 1; flush_cnt increments each cycle any flush = 1; both wrap at 2^32.
- o_busy = (state != RUN).

Optional Feature:
- HAZARD_PERF_EN defined: o_stall_cnt/o_flush_cnt are live as above.
- Undefined: counter registers are not synthesized and both outputs are tied to 0; ports remain.

Decomposition:
- Package hazard_pkg: fwd_sel_e enum (FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10), hz_state_e (RUN, LD_STALL, MD_WAIT), REG_X0 constant.
- One natural sub-module fwd_sel_unit: the combinational forward-code logic, instantiated once per operand.

Test Plan:
- add x5 in MEM, EX rs1=x5, WB rd=x5 also writing → o_forward_a=01 (MEM priority); rd=x0 in both → 00.
- lw x6 in EX, ID rs2=x6 use2=1, LOAD_BUBBLES=2 → stall_pc/stall_if_id/flush_id_ex high for exactly 2 cycles, then RUN; next cycle WB-forward code 10.
- Load-use and i_redirect_ex same cycle → flush_if_id=flush_id_ex=1, stall_pc=0, FSM stays RUN.
- i_md_start_ex, i_md_done 5 cycles later → stall_pc/stall_id_ex/flush_ex_mem high 5 cycles, low in done cycle; o_busy matches.
- i_reset pulsed asynchronously mid-MD_WAIT → all outputs 0 without a clock edge; o_stall_cnt=0.
- HAZARD_PERF_EN build: 3 load-use + 2 redirects → o_stall_cnt=3, o_flush_cnt=5 (with LOAD_BUBBLES=1); without macro both read 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
package hazard_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned BUB_CNT_W  = 2;
  localparam int unsigned PERF_CNT_W = 32;

  localparam logic [REG_ADDR_W-1:0] REG_X0 = '0;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    LD_STALL = 2'b01,
    MD_WAIT  = 2'b10
  } hz_state_e;

endpackage

// File: rtl/hazard_ctrl_fwd_sel_unit.sv
// Per-operand EX forward-select: MEM result beats WB result; x0 and in-flight loads never forward from MEM.
module fwd_sel_unit
  import hazard_pkg::*;
#(
  parameter int unsigned ADDR_W = REG_ADDR_W
) (
  input  logic [ADDR_W-1:0] i_rs_addr,
  input  logic [ADDR_W-1:0] i_rd_addr_mem,
  input  logic              i_rd_wren_mem,
  input  logic              i_is_load_mem,
  input  logic [ADDR_W-1:0] i_rd_addr_wb,
  input  logic              i_rd_wren_wb,
  output fwd_sel_e          o_sel
);

  logic mem_hit;
  logic wb_hit;

  assign mem_hit = i_rd_wren_mem && (i_rd_addr_mem != ADDR_W'(REG_X0)) &&
                   (i_rd_addr_mem == i_rs_addr) && !i_is_load_mem;
  assign wb_hit  = i_rd_wren_wb && (i_rd_addr_wb != ADDR_W'(REG_X0)) &&
                   (i_rd_addr_wb == i_rs_addr);

  always_comb begin
    o_sel = FWD_RF;
    if (mem_hit)     o_sel = FWD_MEM;
    else if (wb_hit) o_sel = FWD_WB;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/forwarding controller: forward codes, load-use bubbles, mul/div holds, redirect flushes.
// Define HAZARD_PERF_EN to build the stall/flush performance counters; otherwise they read 0.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned LOAD_BUBBLES = 1,
  parameter int unsigned REG_ADDR_W   = 5
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [REG_ADDR_W-1:0] i_rs1_addr_id,
  input  logic [REG_ADDR_W-1:0] i_rs2_addr_id,
  input  logic                  i_rs1_use_id,
  input  logic                  i_rs2_use_id,
  input  logic [REG_ADDR_W-1:0] i_rs1_addr_ex,
  input  logic [REG_ADDR_W-1:0] i_rs2_addr_ex,
  input  logic [REG_ADDR_W-1:0] i_rd_addr_ex,
  input  logic [REG_ADDR_W-1:0] i_rd_addr_mem,
  input  logic [REG_ADDR_W-1:0] i_rd_addr_wb,
  input  logic                  i_rd_wren_ex,
  input  logic                  i_rd_wren_mem,
  input  logic                  i_rd_wren_wb,
  input  logic                  i_is_load_ex,
  input  logic                  i_is_load_mem,
  input  logic                  i_md_start_ex,
  input  logic                  i_md_done,
  input  logic                  i_redirect_ex,
  output logic [1:0]            o_forward_a,
  output logic [1:0]            o_forward_b,
  output logic                  o_stall_pc,
  output logic                  o_stall_if_id,
  output logic                  o_stall_id_ex,
  output logic                  o_flush_if_id,
  output logic                  o_flush_id_ex,
  output logic                  o_flush_ex_mem,
  output logic                  o_busy,
  output logic [31:0]           o_stall_cnt,
  output logic [31:0]           o_flush_cnt
);

  localparam logic [BUB_CNT_W-1:0] BUB_INIT = BUB_CNT_W'(LOAD_BUBBLES - 1);
  localparam logic                 MULTI_BUB = (LOAD_BUBBLES > 1);

  fwd_sel_e fwd_a;
  fwd_sel_e fwd_b;

  fwd_sel_unit #(.ADDR_W(REG_ADDR_W)) u_fwd_a (
    .i_rs_addr     (i_rs1_addr_ex),
    .i_rd_addr_mem (i_rd_addr_mem),
    .i_rd_wren_mem (i_rd_wren_mem),
    .i_is_load_mem (i_is_load_mem),
    .i_rd_addr_wb  (i_rd_addr_wb),
    .i_rd_wren_wb  (i_rd_wren_wb),
    .o_sel         (fwd_a)
  );

  fwd_sel_unit #(.ADDR_W(REG_ADDR_W)) u_fwd_b (
    .i_rs_addr     (i_rs2_addr_ex),
    .i_rd_addr_mem (i_rd_addr_mem),
    .i_rd_wren_mem (i_rd_wren_mem),
    .i_is_load_mem (i_is_load_mem),
    .i_rd_addr_wb  (i_rd_addr_wb),
    .i_rd_wren_wb  (i_rd_wren_wb),
    .o_sel         (fwd_b)
  );

  assign o_forward_a = fwd_a;
  assign o_forward_b = fwd_b;

  logic load_use;
  assign load_use = i_is_load_ex && i_rd_wren_ex && (i_rd_addr_ex != REG_ADDR_W'(REG_X0)) &&
                    ((i_rs1_use_id && (i_rs1_addr_id == i_rd_addr_ex)) ||
                     (i_rs2_use_id && (i_rs2_addr_id == i_rd_addr_ex)));

  hz_state_e             state_q, state_d;
  logic [BUB_CNT_W-1:0]  bub_q, bub_d;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= RUN;
      bub_q   <= '0;
    end else begin
      state_q <= state_d;
      bub_q   <= bub_d;
    end
  end

  // Stall/flush controls respond in the same cycle as the hazard they cover.
  always_comb begin
    state_d        = state_q;
    bub_d          = bub_q;
    o_stall_pc     = 1'b0;
    o_stall_if_id  = 1'b0;
    o_stall_id_ex  = 1'b0;
    o_flush_if_id  = 1'b0;
    o_flush_id_ex  = 1'b0;
    o_flush_ex_mem = 1'b0;
    unique case (state_q)
      RUN: begin
        if (i_redirect_ex) begin
          o_flush_if_id = 1'b1;
          o_flush_id_ex = 1'b1;
        end else if (load_use) begin
          o_stall_pc    = 1'b1;
          o_stall_if_id = 1'b1;
          o_flush_id_ex = 1'b1;
          if (MULTI_BUB) begin
            state_d = LD_STALL;
            bub_d   = BUB_INIT;
          end
        end else if (i_md_start_ex && !i_md_done) begin
          state_d = MD_WAIT;
        end
      end
      LD_STALL: begin
        o_stall_pc    = 1'b1;
        o_stall_if_id = 1'b1;
        o_flush_id_ex = 1'b1;
        bub_d         = bub_q - BUB_CNT_W'(1);
        if (bub_q == BUB_CNT_W'(1)) state_d = RUN;
      end
      MD_WAIT: begin
        if (i_md_done) begin
          state_d = RUN;
        end else begin
          o_stall_pc     = 1'b1;
          o_stall_if_id  = 1'b1;
          o_stall_id_ex  = 1'b1;
          o_flush_ex_mem = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  assign o_busy = (state_q != RUN);

`ifdef HAZARD_PERF_EN
  logic [PERF_CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic                  any_flush;

  assign any_flush = o_flush_if_id || o_flush_id_ex || o_flush_ex_mem;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (o_stall_pc) stall_cnt_q <= stall_cnt_q + PERF_CNT_W'(1);
      if (any_flush)  flush_cnt_q <= flush_cnt_q + PERF_CNT_W'(1);
    end
  end

  assign o_stall_cnt = stall_cnt_q;
  assign o_flush_cnt = flush_cnt_q;
`else
  assign o_stall_cnt = '0;
  assign o_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (LOAD_BUBBLES=2) with an expected-output scoreboard queue.
module tb_hazard_ctrl;

  localparam int unsigned AW = 5;

  // Observed vector: {fwd_a, fwd_b, stall_pc, stall_if_id, stall_id_ex, flush_if_id, flush_id_ex, flush_ex_mem, busy}
  localparam logic [6:0] C_IDLE = 7'b000_000_0;
  localparam logic [6:0] C_LU   = 7'b110_010_0;
  localparam logic [6:0] C_LD   = 7'b110_010_1;
  localparam logic [6:0] C_RD   = 7'b000_110_0;
  localparam logic [6:0] C_MD   = 7'b111_001_1;
  localparam logic [6:0] C_DONE = 7'b000_000_1;

  typedef struct {
    string       tag;
    logic [10:0] vec;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, rd_mem, rd_wb;
  logic          use1, use2, wren_ex, wren_mem, wren_wb, ld_ex, ld_mem;
  logic          md_start, md_done, redirect;
  logic [1:0]    fa, fb;
  logic          spc, sifid, sidex, fifid, fidex, fexmem, busy;
  logic [31:0]   stall_cnt, flush_cnt;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  hazard_ctrl #(.LOAD_BUBBLES(2), .REG_ADDR_W(AW)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_rs1_addr_id(rs1_id), .i_rs2_addr_id(rs2_id),
    .i_rs1_use_id(use1), .i_rs2_use_id(use2),
    .i_rs1_addr_ex(rs1_ex), .i_rs2_addr_ex(rs2_ex),
    .i_rd_addr_ex(rd_ex), .i_rd_addr_mem(rd_mem), .i_rd_addr_wb(rd_wb),
    .i_rd_wren_ex(wren_ex), .i_rd_wren_mem(wren_mem), .i_rd_wren_wb(wren_wb),
    .i_is_load_ex(ld_ex), .i_is_load_mem(ld_mem),
    .i_md_start_ex(md_start), .i_md_done(md_done), .i_redirect_ex(redirect),
    .o_forward_a(fa), .o_forward_b(fb),
    .o_stall_pc(spc), .o_stall_if_id(sifid), .o_stall_id_ex(sidex),
    .o_flush_if_id(fifid), .o_flush_id_ex(fidex), .o_flush_ex_mem(fexmem),
    .o_busy(busy), .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt)
  );

  wire [10:0] obs = {fa, fb, spc, sifid, sidex, fifid, fidex, fexmem, busy};

  task automatic idle();
    rs1_id = '0; rs2_id = '0; rs1_ex = '0; rs2_ex = '0;
    rd_ex = '0; rd_mem = '0; rd_wb = '0;
    use1 = 1'b0; use2 = 1'b0; wren_ex = 1'b0; wren_mem = 1'b0; wren_wb = 1'b0;
    ld_ex = 1'b0; ld_mem = 1'b0; md_start = 1'b0; md_done = 1'b0; redirect = 1'b0;
  endtask

  task automatic push(input string tag, input logic [1:0] ea, input logic [1:0] eb,
                      input logic [6:0] ctl);
    exp_t e;
    e.tag = tag;
    e.vec = {ea, eb, ctl};
    sb.push_back(e);
  endtask

  task automatic check_now();
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard: observed %b with no expected entry", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.vec) else begin
        n_bad++;
        $error("FAIL %s: observed %b expected %b", e.tag, obs, e.vec);
      end
    end
  endtask

  task automatic check_cnt(input string tag, input logic [31:0] o, input logic [31:0] x);
    n_cmp++;
    assert (o === x) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, o, x);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_now();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    push("reset", 2'b00, 2'b00, C_IDLE);
    @(negedge clk);
    check_now();
    check_cnt("reset_stall_cnt", stall_cnt, 32'd0);
    check_cnt("reset_flush_cnt", flush_cnt, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Forwarding priority and x0 exclusion
    rd_mem = 5'd5; wren_mem = 1'b1; rd_wb = 5'd5; wren_wb = 1'b1; rs1_ex = 5'd5; rs2_ex = 5'd5;
    push("fwd_mem_prio", 2'b01, 2'b01, C_IDLE); tick();
    ld_mem = 1'b1; rs2_ex = 5'd3;
    push("fwd_load_in_mem", 2'b10, 2'b00, C_IDLE); tick();
    idle(); wren_mem = 1'b1; wren_wb = 1'b1;
    push("fwd_x0", 2'b00, 2'b00, C_IDLE); tick();
    idle(); rd_wb = 5'd9; wren_wb = 1'b1; rs1_ex = 5'd9; rs2_ex = 5'd3;
    push("fwd_wb_only", 2'b10, 2'b00, C_IDLE); tick();

    // Load-use with two bubbles, then WB forward
    idle(); ld_ex = 1'b1; wren_ex = 1'b1; rd_ex = 5'd6; rs2_id = 5'd6; use2 = 1'b1;
    push("lu_bubble1", 2'b00, 2'b00, C_LU); tick();
    idle();
    push("lu_bubble2", 2'b00, 2'b00, C_LD); tick();
    rd_wb = 5'd6; wren_wb = 1'b1; rs2_ex = 5'd6;
    push("lu_after_wb_fwd", 2'b00, 2'b10, C_IDLE); tick();

    // No hazard for x0 destination or unused source
    idle(); ld_ex = 1'b1; wren_ex = 1'b1; rd_ex = 5'd0; use1 = 1'b1;
    push("lu_x0", 2'b00, 2'b00, C_IDLE); tick();
    rd_ex = 5'd6; use1 = 1'b0; rs2_id = 5'd6;
    push("lu_unused_src", 2'b00, 2'b00, C_IDLE); tick();

    // Redirect beats load-use
    use1 = 1'b1; rs1_id = 5'd6; redirect = 1'b1;
    push("redirect_vs_lu", 2'b00, 2'b00, C_RD); tick();
    idle();
    push("redirect_stays_run", 2'b00, 2'b00, C_IDLE); tick();

    // Multi-cycle mul/div hold, redirect ignored while waiting
    md_start = 1'b1;
    push("md_start", 2'b00, 2'b00, C_IDLE); tick();
    idle();
    for (int i = 0; i < 5; i++) begin
      redirect = (i == 2);
      push("md_wait", 2'b00, 2'b00, C_MD); tick();
    end
    idle(); md_done = 1'b1;
    push("md_done", 2'b00, 2'b00, C_DONE); tick();
    idle();
    push("md_back_run", 2'b00, 2'b00, C_IDLE); tick();

    // Single-cycle mul/div: start and done together
    md_start = 1'b1; md_done = 1'b1;
    push("md_single", 2'b00, 2'b00, C_IDLE); tick();
    idle();
    push("md_single_after", 2'b00, 2'b00, C_IDLE); tick();

    // Asynchronous reset in the middle of MD_WAIT
    md_start = 1'b1;
    push("md2_start", 2'b00, 2'b00, C_IDLE); tick();
    idle();
    push("md2_wait", 2'b00, 2'b00, C_MD); check_now();
    #2 rst = 1'b1;
    #1;
    push("async_reset", 2'b00, 2'b00, C_IDLE); check_now();
    check_cnt("async_reset_stall_cnt", stall_cnt, 32'd0);
    check_cnt("async_reset_flush_cnt", flush_cnt, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Performance counters: 3 load-use (2 bubbles each) + 2 redirects
    for (int k = 0; k < 3; k++) begin
      idle(); ld_ex = 1'b1; wren_ex = 1'b1; rd_ex = 5'd7; rs1_id = 5'd7; use1 = 1'b1;
      push("perf_lu", 2'b00, 2'b00, C_LU); tick();
      idle();
      push("perf_ld", 2'b00, 2'b00, C_LD); tick();
    end
    for (int k = 0; k < 2; k++) begin
      redirect = 1'b1;
      push("perf_rd", 2'b00, 2'b00, C_RD); tick();
    end
    idle();
    @(negedge clk);
`ifdef HAZARD_PERF_EN
    check_cnt("perf_stall_cnt", stall_cnt, 32'd6);
    check_cnt("perf_flush_cnt", flush_cnt, 32'd8);
`else
    check_cnt("perf_stall_cnt", stall_cnt, 32'd0);
    check_cnt("perf_flush_cnt", flush_cnt, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
